// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM encoding, default line size and error fill word for the memory responder
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WB, RD_WAIT, RD_BURST} state_t;
    localparam int LINE_WORDS_DEF = 4;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_resp_sp_ram.sv
// mem_resp_sp_ram: single-port byte-enabled RAM with registered read data
module mem_resp_sp_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dcache_mem_resp.sv
// dcache_mem_resp: D-cache refill (critical-word-first burst) and write-back responder.
// Define MEM_RESP_ADDR_CHK_EN to flag and neutralise requests above the backing store.
module dcache_mem_resp
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int RD_LAT     = 2,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_rd_req_i,
    input  logic [31:0] ram_rd_addr_i,
    output logic        ram_rd_valid_o,
    output logic [31:0] ram_rd_data_o,
    output logic        ram_rd_last_o,
    input  logic        ram_wr_req_i,
    input  logic [31:0] ram_wr_addr_i,
    input  logic [31:0] ram_wr_data_i,
    input  logic [3:0]  ram_wr_en_i,
    output logic        ram_wr_ack_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int OW = $clog2(LINE_WORDS);
    state_t                 state;
    logic [MEM_AW-OW-1:0]   line;
    logic [OW-1:0]          crit, idx, off;
    logic [3:0]             cnt;
    logic                   bad, rd_oor, wr_oor, ram_we;
    logic [MEM_AW-1:0]      ram_addr;
    logic [31:0]            rdata;
    logic                   unused_addr;
    assign unused_addr = ^{ram_rd_addr_i[1:0], ram_rd_addr_i[31:MEM_AW+2],
                           ram_wr_addr_i[OW+1:0], ram_wr_addr_i[31:MEM_AW+2]};
`ifdef MEM_RESP_ADDR_CHK_EN
    assign rd_oor = |ram_rd_addr_i[31:MEM_AW+2];
    assign wr_oor = |ram_wr_addr_i[31:MEM_AW+2];
    always_ff @(posedge clk) begin
        if (!rst_n) err_o <= 1'b0;
        else err_o <= state == IDLE && (ram_wr_req_i ? wr_oor : ram_rd_req_i && rd_oor);
    end
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
    assign err_o  = 1'b0;
`endif
    // The RAM read runs two beats ahead of the output register to cover its own latency.
    always_comb begin
        off = (state == RD_BURST) ? crit + idx + OW'(2)
            : (state == RD_WAIT && cnt == '0) ? crit + OW'(1)
            : (state == WB) ? idx : crit;
        ram_addr = (state != IDLE) ? {line, off}
                 : ram_wr_req_i ? {ram_wr_addr_i[MEM_AW+1:OW+2], {OW{1'b0}}}
                 : ram_rd_addr_i[MEM_AW+1:2];
        ram_we = ram_wr_req_i && ((state == IDLE && !wr_oor) || (state == WB && !bad));
    end
    mem_resp_sp_ram #(.AW(MEM_AW)) u_ram (
        .clk(clk), .we(ram_we), .be(ram_wr_en_i), .addr(ram_addr),
        .wdata(ram_wr_data_i), .rdata(rdata)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            line <= '0;
            crit <= '0;
            idx <= '0;
            cnt <= '0;
            bad <= 1'b0;
            ram_rd_valid_o <= 1'b0;
            ram_rd_data_o <= '0;
            ram_rd_last_o <= 1'b0;
            ram_wr_ack_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            ram_wr_ack_o <= 1'b0;
            case (state)
                IDLE: if (ram_wr_req_i) begin
                    state <= WB;
                    line <= ram_wr_addr_i[MEM_AW+1:OW+2];
                    idx <= OW'(1);
                    bad <= wr_oor;
                    ram_wr_ack_o <= 1'b1;
                    busy_o <= 1'b1;
                end else if (ram_rd_req_i) begin
                    state <= RD_WAIT;
                    line <= ram_rd_addr_i[MEM_AW+1:OW+2];
                    crit <= ram_rd_addr_i[OW+1:2];
                    cnt <= 4'(RD_LAT - 1);
                    bad <= rd_oor;
                    busy_o <= 1'b1;
                end
                WB: if (ram_wr_req_i) begin
                    ram_wr_ack_o <= 1'b1;
                    idx <= idx + 1'b1;
                    if (idx == OW'(LINE_WORDS - 1)) begin
                        state <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                RD_WAIT: if (cnt == '0) begin
                    state <= RD_BURST;
                    idx <= '0;
                    ram_rd_valid_o <= 1'b1;
                    ram_rd_data_o <= bad ? ERR_WORD : rdata;
                    ram_rd_last_o <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RD_BURST: if (idx == OW'(LINE_WORDS - 1)) begin
                    state <= IDLE;
                    ram_rd_valid_o <= 1'b0;
                    ram_rd_data_o <= '0;
                    ram_rd_last_o <= 1'b0;
                    busy_o <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                    ram_rd_data_o <= bad ? ERR_WORD : rdata;
                    ram_rd_last_o <= idx == OW'(LINE_WORDS - 2);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
